// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single shared BRAM.
//
// Ports
//   clk, resetn                 clock (rising edge), asynchronous active-low reset
//   m0_* / m1_*                 requester ports (0 = CPU, 1 = loader/debug):
//                               req/addr/wdata/mask/we in; ack/rdata/err out
//   memAddress, memWriteData,   shared BRAM address/data/lane mask/write strobe,
//   byteMask, memWrite          driven only during the ACCESS cycle
//   memReadData                 BRAM read data, one cycle after the address
//
// Each access takes IDLE -> ACCESS -> RESP: req sampled at edge N, BRAM
// cycle during N+1, one-cycle ack during N+2. Accesses outside
// [BASE_MEMORY, TOP_MEMORY] complete with err=1 and never strobe memWrite.
//
// Build option: define MEM_ARB_FIXED_PRIO_EN to make port 0 always win
// simultaneous requests; otherwise the arbitration is round-robin.

module mem_arbiter #(
  parameter logic [31:0] BASE_MEMORY = 32'h0000_0000,
  parameter logic [31:0] TOP_MEMORY  = 32'h0000_01ff
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m0_mask,
  input  logic [3:0]  m1_mask,
  input  logic        m0_we,
  input  logic        m1_we,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [3:0]  byteMask,
  output logic        memWrite,
  input  logic [31:0] memReadData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q;

  // Latched request attributes kept for the response phase
  logic        gnt_q;
  logic        we_q;
  logic        inwin_q;

  // Registered BRAM-side outputs (non-zero only during ACCESS)
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_mask_q;
  logic        mem_write_q;

  // Registered response flags; rdN_q marks a read whose data must be passed on
  logic        ack0_q, ack1_q;
  logic        err0_q, err1_q;
  logic        rd0_q,  rd1_q;

`ifdef MEM_ARB_FIXED_PRIO_EN
`else
  logic        last_q;
`endif

  // Winner selection and its request fields
  logic        win_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic [3:0]  mask_d;
  logic        we_d;
  logic        inwin_d;

  always_comb begin
    win_d = 1'b0;
    if (m0_req && m1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      win_d = 1'b0;
`else
      win_d = ~last_q;
`endif
    end else begin
      win_d = m1_req;
    end
    addr_d  = win_d ? m1_addr  : m0_addr;
    wdata_d = win_d ? m1_wdata : m0_wdata;
    mask_d  = win_d ? m1_mask  : m0_mask;
    we_d    = win_d ? m1_we    : m0_we;
    // Single unsigned compare: the wrap of (addr - BASE) pushes addresses
    // below BASE above the window size, so both bounds are covered at once.
    inwin_d = (addr_d - BASE_MEMORY) <= (TOP_MEMORY - BASE_MEMORY);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      inwin_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      mem_write_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rd0_q       <= 1'b0;
      rd1_q       <= 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
      last_q      <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            state_q     <= ACCESS;
            gnt_q       <= win_d;
            we_q        <= we_d;
            inwin_q     <= inwin_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            mem_mask_q  <= mask_d;
            mem_write_q <= we_d & inwin_d;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
            last_q      <= win_d;
`endif
          end
        end
        ACCESS: begin
          state_q     <= RESP;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          mem_mask_q  <= '0;
          mem_write_q <= 1'b0;
          ack0_q      <= ~gnt_q;
          ack1_q      <=  gnt_q;
          err0_q      <= ~gnt_q & ~inwin_q;
          err1_q      <=  gnt_q & ~inwin_q;
          rd0_q       <= ~gnt_q & ~we_q & inwin_q;
          rd1_q       <=  gnt_q & ~we_q & inwin_q;
        end
        RESP: begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          rd0_q   <= 1'b0;
          rd1_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memAddress   = mem_addr_q;
  assign memWriteData = mem_wdata_q;
  assign byteMask     = mem_mask_q;
  assign memWrite     = mem_write_q;

  assign m0_ack   = ack0_q;
  assign m1_ack   = ack1_q;
  assign m0_err   = err0_q;
  assign m1_err   = err1_q;
  // BRAM data arrives during RESP, so it is gated rather than registered
  assign m0_rdata = rd0_q ? memReadData : '0;
  assign m1_rdata = rd1_q ? memReadData : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// traffic, all checked every cycle against a transaction-level model.

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_mask, m1_mask;
  logic        m0_we, m1_we;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] memAddress, memWriteData;
  logic [3:0]  byteMask;
  logic        memWrite;
  logic [31:0] memReadData = '0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .BASE_MEMORY(32'h0000_0000),
    .TOP_MEMORY (32'h0000_01ff)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_mask(m0_mask), .m1_mask(m1_mask),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_err(m0_err), .m1_err(m1_err),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .byteMask(byteMask), .memWrite(memWrite),
    .memReadData(memReadData)
  );

  // BRAM environment: 128 words, registered read
  logic [31:0] bram [128];
  logic [31:0] lane_m;
  assign lane_m = {{8{byteMask[3]}}, {8{byteMask[2]}}, {8{byteMask[1]}}, {8{byteMask[0]}}};
  initial foreach (bram[i]) bram[i] = '0;
  always @(posedge clk) begin
    if (memWrite)
      bram[memAddress[8:2]] <= (bram[memAddress[8:2]] & ~lane_m) | (memWriteData & lane_m);
    memReadData <= bram[memAddress[8:2]];
  end

  // ---------------- reference model (transaction level) ----------------
  int          k = 0;          // posedge count
  int          g_edge = -100;  // edge at which the current access was granted
  int          free_at = 0;    // first edge at which a new grant may occur
  int          last_g = 1;
  int          gp = 0;
  logic [31:0] ga = '0, gd = '0;
  logic [3:0]  gm = '0;
  logic        gw = 1'b0;
  logic [31:0] mm [128];

  int n_cmp = 0;
  int n_err = 0;

  int          ackp_q[$];
  int          ackt_q[$];
  logic [31:0] ackd_q[$];
  logic        acke_q[$];
  bit          got0, got1;

  function automatic bit in_win(logic [31:0] a);
    return a < 32'h0000_0200;
  endfunction

  task automatic model_reset();
    g_edge  = -100;
    free_at = 0;
    last_g  = 1;
  endtask

  task automatic model_step();
    if (k == g_edge + 1 && gw && in_win(ga))
      for (int i = 0; i < 4; i++)
        if (gm[i]) mm[ga[8:2]][8*i +: 8] = gd[8*i +: 8];
    if (k >= free_at && (m0_req || m1_req)) begin
      if (m0_req && m1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        gp = 0;
`else
        gp = (last_g == 0) ? 1 : 0;
`endif
      end else begin
        gp = m0_req ? 0 : 1;
      end
      ga = gp ? m1_addr  : m0_addr;
      gd = gp ? m1_wdata : m0_wdata;
      gm = gp ? m1_mask  : m0_mask;
      gw = gp ? m1_we    : m0_we;
      g_edge  = k;
      free_at = k + 3;
      last_g  = gp;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic check_outputs();
    bit          acc, rsp, iw;
    logic [31:0] rd;
    acc = (k == g_edge);
    rsp = (k == g_edge + 1);
    iw  = in_win(ga);
    rd  = (rsp && !gw && iw) ? mm[ga[8:2]] : '0;
    chk("memWrite",     32'(memWrite),     32'(acc && gw && iw));
    chk("memAddress",   memAddress,        acc ? ga : '0);
    chk("memWriteData", memWriteData,      acc ? gd : '0);
    chk("byteMask",     32'(byteMask),     acc ? 32'(gm) : '0);
    chk("m0_ack",       32'(m0_ack),       32'(rsp && gp == 0));
    chk("m1_ack",       32'(m1_ack),       32'(rsp && gp == 1));
    chk("m0_err",       32'(m0_err),       32'(rsp && gp == 0 && !iw));
    chk("m1_err",       32'(m1_err),       32'(rsp && gp == 1 && !iw));
    chk("m0_rdata",     m0_rdata,          (gp == 0) ? rd : '0);
    chk("m1_rdata",     m1_rdata,          (gp == 1) ? rd : '0);
    if (m0_ack) begin
      got0 = 1'b1;
      ackp_q.push_back(0); ackt_q.push_back(k);
      ackd_q.push_back(m0_rdata); acke_q.push_back(m0_err);
    end
    if (m1_ack) begin
      got1 = 1'b1;
      ackp_q.push_back(1); ackt_q.push_back(k);
      ackd_q.push_back(m1_rdata); acke_q.push_back(m1_err);
    end
  endtask

  task automatic tick();
    got0 = 1'b0;
    got1 = 1'b0;
    @(posedge clk);
    k++;
    if (!resetn) model_reset();
    else         model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_acks();
    ackp_q.delete(); ackt_q.delete(); ackd_q.delete(); acke_q.delete();
  endtask

  task automatic drive(int p, logic rq, logic [31:0] a, logic [31:0] d, logic [3:0] m, logic w);
    if (p == 0) begin
      m0_req = rq; m0_addr = a; m0_wdata = d; m0_mask = m; m0_we = w;
    end else begin
      m1_req = rq; m1_addr = a; m1_wdata = d; m1_mask = m; m1_we = w;
    end
  endtask

  // One isolated access from idle; returns ack latency (-1 if none), data, err
  task automatic xact(int p, logic [31:0] a, logic [31:0] d, logic [3:0] m, logic w,
                      output int lat, output logic [31:0] rd, output logic er);
    clear_acks();
    drive(p, 1'b1, a, d, m, w);
    lat = -1; rd = 'x; er = 1'bx;
    for (int t = 1; t <= 8 && lat < 0; t++) begin
      tick();
      if (ackp_q.size() != 0) begin
        lat = t; rd = ackd_q[0]; er = acke_q[0];
      end
    end
    drive(p, 1'b0, '0, '0, '0, 1'b0);
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0200 + 32'($urandom_range(0, 255));
      1:       return $urandom;
      2:       return 32'h0000_01fc + 32'($urandom_range(0, 7));
      default: return 32'($urandom_range(0, 511));
    endcase
  endfunction

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    bit          act0, act1;

    foreach (mm[i]) mm[i] = '0;
    resetn = 1'b0;
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Write then read back through port 0
    xact(0, 32'h004, 32'hDEADBEEF, 4'b1111, 1'b1, lat, rd, er);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_err", 32'(er), 32'd0);
    xact(0, 32'h004, 32'h0, 4'b1111, 1'b0, lat, rd, er);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(er), 32'd0);

    // Single byte-lane update
    xact(0, 32'h004, 32'hAABBCCDD, 4'b0010, 1'b1, lat, rd, er);
    xact(0, 32'h004, 32'h0, 4'b1111, 1'b0, lat, rd, er);
    chk("lane_data", rd, 32'hDEADCCEF);

    // Out-of-window write and read on port 1
    xact(1, 32'h200, 32'h12345678, 4'b1111, 1'b1, lat, rd, er);
    chk("oow_wr_latency", 32'(lat), 32'd2);
    chk("oow_wr_err", 32'(er), 32'd1);
    xact(1, 32'h200, 32'h0, 4'b1111, 1'b0, lat, rd, er);
    chk("oow_rd_data", rd, 32'h0);
    chk("oow_rd_err", 32'(er), 32'd1);

    // Both ports holding requests (last grant was port 1)
    clear_acks();
    drive(0, 1'b1, 32'h004, '0, 4'hF, 1'b0);
    drive(1, 1'b1, 32'h008, '0, 4'hF, 1'b0);
    repeat (12) tick();
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    repeat (2) tick();
    chk("both_ack_count", 32'(ackp_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < ackp_q.size(); i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      chk("both_grant_port", 32'(ackp_q[i]), 32'd0);
`else
      chk("both_grant_port", 32'(ackp_q[i]), 32'(i % 2));
`endif
      if (i > 0) chk("both_ack_spacing", 32'(ackt_q[i] - ackt_q[i-1]), 32'd3);
    end

    // Reset during the ACCESS cycle of a port-0 write
    clear_acks();
    drive(0, 1'b1, 32'h010, 32'h0BADF00D, 4'hF, 1'b1);
    tick();
    chk("pre_reset_memWrite", 32'(memWrite), 32'd1);
    #1 resetn = 1'b0;
    #1 model_reset();
    chk("reset_memWrite_async", 32'(memWrite), 32'd0);
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    repeat (2) tick();
    chk("reset_no_ack", 32'(ackp_q.size()), 32'd0);
    resetn = 1'b1;
    drive(0, 1'b1, 32'h010, '0, 4'hF, 1'b0);
    drive(1, 1'b1, 32'h004, '0, 4'hF, 1'b0);
    repeat (5) tick();
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    repeat (2) tick();
    chk("post_reset_acks", 32'(ackp_q.size()), 32'd2);
    if (ackp_q.size() >= 2) begin
      chk("post_reset_first", 32'(ackp_q[0]), 32'd0);
      chk("aborted_wr_absent", ackd_q[0], 32'h0);
      chk("post_reset_second_data", ackd_q[1], 32'hDEADCCEF);
    end

    // Randomized traffic; each requester holds until its ack
    act0 = 1'b0;
    act1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (got0) begin act0 = 1'b0; m0_req = 1'b0; end
      if (got1) begin act1 = 1'b0; m1_req = 1'b0; end
      if (!act0 && $urandom_range(0, 2) == 0) begin
        act0 = 1'b1;
        drive(0, 1'b1, rand_addr(), $urandom, 4'($urandom), 1'($urandom));
      end
      if (!act1 && $urandom_range(0, 2) == 0) begin
        act1 = 1'b1;
        drive(1, 1'b1, rand_addr(), $urandom, 4'($urandom), 1'($urandom));
      end
    end
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
